// File: rtl/pong_pkg.sv
// Shared constants for the Pong match logic: screen size, field widths,
// state encodings and a saturating score increment.
package pong_pkg;

    localparam int SCREEN_X = 640;
    localparam int SCREEN_Y = 480;
    localparam int SCORE_W  = 4;
    localparam int FRAME_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } pong_state_e;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] max);
        return (s >= max) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable frame down-counter. done pulses for one cycle on the tick that
// brings the count to zero; a load on the same edge as a tick wins.
module pong_frame_timer
    import pong_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_val,
    input  logic               tick,
    output logic               done
);

    logic [FRAME_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            done  <= 1'b0;
        end else begin
            done <= tick && (count == FRAME_W'(1));
            if (tick && (count != '0))
                count <= count - FRAME_W'(1);
        end
    end

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong match controller: sequences serve/play/point/pause/over, detects goals,
// keeps scores and gates the paddle/ball modules.
module pong_game_sequencer #(
    parameter int SCREEN_X     = 640,
    parameter int LEFT_GOAL    = 2,
    parameter int RIGHT_GOAL   = 638,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic                        start,
    input  logic                        pause,
    input  logic [9:0]                  ball_x,
    input  logic [7:0]                  ball_size_x,
    output logic                        objects_rst_n,
    output logic                        play_en,
    output logic                        serve_dir,
    output logic [pong_pkg::SCORE_W-1:0] score_left,
    output logic [pong_pkg::SCORE_W-1:0] score_right,
    output logic                        game_over,
    output logic                        winner,
    output logic [2:0]                  state
);
    import pong_pkg::*;

    // A right goal line beyond the screen could never be reached; clamp it.
    localparam int GOAL_R = (RIGHT_GOAL < SCREEN_X) ? RIGHT_GOAL : SCREEN_X;
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    logic               start_q, pause_q, start_rise, pause_rise;
    logic               goal_left, goal_right;
    logic               done, load, clear, hit_left, hit_right, timer_tick;
    logic [FRAME_W-1:0] load_val;
    logic [2:0]         nxt;
    logic [10:0]        sum;

    assign sum        = {1'b0, ball_x} + {3'b000, ball_size_x};
    assign timer_tick = frame_tick && ((state == ST_SERVE) || (state == ST_POINT));

    pong_frame_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (timer_tick),
        .done     (done)
    );

    // Edge pulses and goal flags are registered, so every decision below acts
    // one edge after the input was sampled.
    always_comb begin
        nxt       = state;
        load      = 1'b0;
        load_val  = FRAME_W'(SERVE_FRAMES);
        clear     = 1'b0;
        hit_left  = 1'b0;
        hit_right = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    nxt   = ST_SERVE;
                    load  = 1'b1;
                    clear = 1'b1;
                end
            end
            ST_SERVE: begin
                if (done)
                    nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (goal_left) begin
                    hit_left = 1'b1;
                    nxt      = ST_POINT;
                    load     = 1'b1;
                    load_val = FRAME_W'(POINT_FRAMES);
                end else if (goal_right) begin
                    hit_right = 1'b1;
                    nxt       = ST_POINT;
                    load      = 1'b1;
                    load_val  = FRAME_W'(POINT_FRAMES);
                end else if (pause_rise) begin
                    nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                // Abort takes precedence over resume if both buttons rise together.
                if (start_rise)
                    nxt = ST_IDLE;
                else if (pause_rise)
                    nxt = ST_PLAY;
            end
            ST_POINT: begin
                if (done) begin
                    if ((score_left == WIN) || (score_right == WIN)) begin
                        nxt = ST_OVER;
                    end else begin
                        nxt  = ST_SERVE;
                        load = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    nxt   = ST_SERVE;
                    load  = 1'b1;
                    clear = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            objects_rst_n <= 1'b0;
            play_en       <= 1'b0;
            serve_dir     <= 1'b0;
            score_left    <= '0;
            score_right   <= '0;
            game_over     <= 1'b0;
            winner        <= 1'b0;
            start_q       <= 1'b1;
            pause_q       <= 1'b1;
            start_rise    <= 1'b0;
            pause_rise    <= 1'b0;
            goal_left     <= 1'b0;
            goal_right    <= 1'b0;
        end else begin
            start_q    <= start;
            pause_q    <= pause;
            start_rise <= start && !start_q;
            pause_rise <= pause && !pause_q;
            goal_left  <= (ball_x <= 10'(LEFT_GOAL));
            goal_right <= (sum >= 11'(GOAL_R));

            state         <= nxt;
            objects_rst_n <= (nxt == ST_SERVE) || (nxt == ST_PLAY) || (nxt == ST_PAUSE);
            play_en       <= (nxt == ST_PLAY);
            game_over     <= (nxt == ST_OVER);

            if (clear) begin
                score_left  <= '0;
                score_right <= '0;
            end else if (hit_left) begin
                score_right <= sat_inc(score_right, WIN);
                serve_dir   <= 1'b0;
            end else if (hit_right) begin
                score_left <= sat_inc(score_left, WIN);
                serve_dir  <= 1'b1;
            end

            if ((state == ST_POINT) && (nxt == ST_OVER))
                winner <= (score_right == WIN);
        end
    end

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: directed match scenarios followed by random
// play, all compared each cycle against a phase/tick-count model of the rules.
module tb_pong_game_sequencer;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3, M_POINT = 4, M_OVER = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [9:0] ball_x = 10'd300;
    logic [7:0] ball_size_x = 8'd8;
    logic       objects_rst_n, play_en, serve_dir, game_over, winner;
    logic [3:0] score_left, score_right;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    pong_game_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .start         (start),
        .pause         (pause),
        .ball_x        (ball_x),
        .ball_size_x   (ball_size_x),
        .objects_rst_n (objects_rst_n),
        .play_en       (play_en),
        .serve_dir     (serve_dir),
        .score_left    (score_left),
        .score_right   (score_right),
        .game_over     (game_over),
        .winner        (winner),
        .state         (state)
    );

    always #5 clock = ~clock;

    // Reference model: match phase, scores and ticks still to wait. Inputs
    // sampled at one edge take effect on the following edge.
    int m_st = M_IDLE, m_sl = 0, m_sr = 0, m_dir = 0, m_win = 0, m_left = 0;
    bit m_new = 0;
    bit p_srise = 0, p_prise = 0, p_tick = 0;
    int p_bx = 300, p_bs = 0;
    bit prev_start = 1, prev_pause = 1;

    function void enter(input int s, input int frames);
        m_st   = s;
        m_left = frames;
        m_new  = 1;
    endfunction

    function void model_step();
        bit counted, expired, gl, gr;
        if (reset) begin
            m_st = M_IDLE; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0; m_left = 0; m_new = 0;
            p_srise = 0; p_prise = 0; p_tick = 0; p_bx = 300; p_bs = 0;
            prev_start = 1; prev_pause = 1;
            return;
        end
        gl      = (p_bx <= 2);
        gr      = (p_bx + p_bs >= 638);
        counted = p_tick && (m_st == M_SERVE || m_st == M_POINT) && !m_new;
        expired = counted && (m_left == 1);
        if (counted && m_left > 0) m_left--;
        m_new = 0;
        case (m_st)
            M_IDLE:  if (p_srise) begin m_sl = 0; m_sr = 0; enter(M_SERVE, 60); end
            M_SERVE: if (expired) enter(M_PLAY, 0);
            M_PLAY: begin
                if (gl) begin
                    if (m_sr < 9) m_sr++;
                    m_dir = 0; enter(M_POINT, 30);
                end else if (gr) begin
                    if (m_sl < 9) m_sl++;
                    m_dir = 1; enter(M_POINT, 30);
                end else if (p_prise) enter(M_PAUSE, 0);
            end
            M_PAUSE: begin
                if (p_srise) enter(M_IDLE, 0);
                else if (p_prise) enter(M_PLAY, 0);
            end
            M_POINT: if (expired) begin
                if (m_sl == 9 || m_sr == 9) begin
                    m_win = (m_sr == 9); enter(M_OVER, 0);
                end else enter(M_SERVE, 60);
            end
            M_OVER:  if (p_srise) begin m_sl = 0; m_sr = 0; enter(M_SERVE, 60); end
            default: m_st = M_IDLE;
        endcase
        p_srise = start && !prev_start;
        p_prise = pause && !prev_pause;
        prev_start = start;
        prev_pause = pause;
        p_tick = frame_tick;
        p_bx   = int'(ball_x);
        p_bs   = int'(ball_size_x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [15:0] obs, exp;
        bit go;
        @(posedge clock);
        model_step();
        #1;
        go  = (m_st == M_OVER);
        exp = {3'(m_st), 1'(m_st == M_SERVE || m_st == M_PLAY || m_st == M_PAUSE),
               1'(m_st == M_PLAY), 1'(m_dir), 4'(m_sl), 4'(m_sr), go, go ? 1'(m_win) : 1'b0};
        obs = {state, objects_rst_n, play_en, serve_dir, score_left, score_right,
               game_over, go ? winner : 1'b0};
        chk("model", 32'(obs), 32'(exp));
    endtask

    // Issue n frame ticks with random idle gaps between them.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
            frame_tick = 1'b1;
            cyc();
        end
        frame_tick = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1; cyc();
        start = 1'b0; cyc();
    endtask

    // Put the ball in a goal for one cycle; caller is in PLAY.
    task automatic goal(input bit at_left);
        if (at_left) begin
            ball_x = 10'($urandom_range(0, 2)); ball_size_x = 8'd8;
        end else begin
            ball_x = 10'($urandom_range(630, 1000)); ball_size_x = 8'd8;
        end
        cyc();
        ball_x = 10'd300;
        cyc();
    endtask

    initial begin
        // Start held through reset must not trigger.
        reset = 1'b1; start = 1'b1;
        repeat (3) cyc();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'({objects_rst_n, play_en, serve_dir, game_over, winner, score_left, score_right}), 32'd0);
        reset = 1'b0;
        repeat (10) cyc();
        chk("held_start_idle", 32'(state), 32'd0);
        start = 1'b0; cyc();
        start = 1'b1; cyc();
        chk("start_latency", 32'(state), 32'd0);
        cyc();
        chk("start_serve", 32'({state, objects_rst_n, play_en}), 32'({3'd1, 1'b1, 1'b0}));
        start = 1'b0;

        ticks(60);
        chk("serve_before_exp", 32'(state), 32'd1);
        cyc();
        chk("serve_to_play", 32'({state, objects_rst_n, play_en}), 32'({3'd2, 1'b1, 1'b1}));

        ball_x = 10'd2; cyc(); ball_x = 10'd300; cyc();
        chk("left_goal", 32'({state, score_right, serve_dir, objects_rst_n}), 32'({3'd4, 4'd1, 1'b0, 1'b0}));
        ticks(30); cyc();
        chk("point_to_serve", 32'({state, objects_rst_n}), 32'({3'd1, 1'b1}));
        ticks(60); cyc();

        ball_x = 10'd629; ball_size_x = 8'd8;
        repeat (3) cyc();
        chk("no_goal_629", 32'({state, score_left}), 32'({3'd2, 4'd0}));
        ball_x = 10'd630; cyc(); ball_x = 10'd300; cyc();
        chk("right_goal_638", 32'({state, score_left, serve_dir}), 32'({3'd4, 4'd1, 1'b1}));
        ticks(30); cyc(); ticks(60); cyc();

        for (int k = 2; k <= 9; k++) begin
            goal(1'b0);
            ticks(30); cyc();
            if (k < 9) begin ticks(60); cyc(); end
        end
        chk("over", 32'({state, game_over, winner, score_left, score_right}),
            32'({3'd5, 1'b1, 1'b0, 4'd9, 4'd1}));
        frame_tick = 1'b1; ball_x = 10'd0;
        repeat (5) cyc();
        frame_tick = 1'b0; ball_x = 10'd300;
        chk("over_frozen", 32'({state, score_left, score_right}), 32'({3'd5, 4'd9, 4'd1}));
        press_start();
        chk("restart", 32'({state, game_over, score_left, score_right}), 32'({3'd1, 1'b0, 8'd0}));

        // Goal and pause rise together: goal wins, pause edge is lost.
        ticks(60); cyc();
        ball_x = 10'd1; pause = 1'b1; cyc();
        ball_x = 10'd300; pause = 1'b0; cyc();
        chk("goal_beats_pause", 32'({state, score_right}), 32'({3'd4, 4'd1}));
        ticks(30); cyc(); ticks(60); cyc();
        chk("no_late_pause", 32'(state), 32'd2);

        pause = 1'b1; cyc(); pause = 1'b0; cyc();
        chk("pause", 32'({state, play_en, objects_rst_n}), 32'({3'd3, 1'b0, 1'b1}));
        pause = 1'b1; cyc(); pause = 1'b0; cyc();
        chk("resume", 32'(state), 32'd2);
        pause = 1'b1; cyc(); pause = 1'b0; cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("reset_mid_pause", 32'({state, objects_rst_n, score_left, score_right}), 32'd0);

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            reset      = ($urandom_range(0, 499) == 0);
            frame_tick = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 59) == 0) start = ~start;
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            r = $urandom_range(0, 99);
            if (r < 5)       ball_x = 10'($urandom_range(0, 2));
            else if (r < 10) ball_x = 10'($urandom_range(600, 1023));
            else             ball_x = 10'($urandom_range(3, 500));
            ball_size_x = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd8;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
